hamming_encoder_stream: RTL and testbench

Streaming Hamming(12,8) single-error-correcting encoder. It is the transmit-side counterpart of the team's 12-bit Hamming decoder.
- Accepts 8-bit data words over a valid/ready handshake.
- Produces 12-bit codewords in exactly the bit layout the decoder consumes.
- Buffers codewords in a 2-entry output queue so both sides can stall independently.
- Optional per-word error injection lets benches exercise the decoder's correction path.

---
 rtl/hamming_encoder_stream.sv | 82 ++++++++
 tb/tb_hamming_encoder_stream.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(12,8) encoder feeding a 2-entry codeword queue.
// Codeword layout matches the team's 12-bit Hamming decoder.
module hamming_encoder_stream #(
  parameter int CNT_W     = 16,
  parameter bit INJECT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      inj_mask,
  output logic [11:0]      out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count
);

  function automatic logic [11:0] encode(
    input logic [7:0] d
  );
    logic [11:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  logic [11:0] mem [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        accept;
  logic        deliver;
  logic [11:0] mask_eff;
  logic [11:0] code_in;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_code  = mem[head];

  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;
  assign mask_eff = INJECT_EN ? inj_mask : 12'h000;
  assign code_in  = encode(in_data) ^ mask_eff;

  // Only the head slot is cleared so out_code reads zero when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      word_count <= '0;
      mem[0]     <= 12'h000;
    end else begin
      if (accept) begin
        mem[tail] <= code_in;
        tail      <= ~tail;
      end
      if (deliver) begin
        head       <= ~head;
        word_count <= word_count + CNT_W'(1);
      end
      unique case ({accept, deliver})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Bench for hamming_encoder_stream: position-based Hamming model,
// FIFO scoreboard checked every cycle, plus directed corner cases.
module tb_hamming_encoder_stream;

  typedef struct packed {
    logic [7:0]  d;
    logic [11:0] m;
  } item_t;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] inj_mask;
  logic [11:0] out_code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_count;

  logic [7:0]  w_in_data;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [11:0] w_inj_mask;
  logic [11:0] w_out_code;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [3:0]  w_word_count;

  int n_checks = 0;
  int n_err    = 0;
  bit live     = 0;

  item_t       stim[$];
  item_t       exp_q[$];
  logic [15:0] m_count;

  hamming_encoder_stream u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .inj_mask(inj_mask),
    .out_code(out_code), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count)
  );

  hamming_encoder_stream #(
    .CNT_W(4), .INJECT_EN(1'b0)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .in_data(w_in_data), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .inj_mask(w_inj_mask),
    .out_code(w_out_code), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .word_count(w_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Textbook Hamming: positions 1..12, checks at powers of two,
  // each check making the XOR of covered positions even.
  function automatic logic [11:0] m_enc(input logic [7:0] d);
    logic [12:1] p;
    int k;
    p = '0;
    k = 0;
    for (int i = 1; i <= 12; i++)
      if ((i & (i - 1)) != 0) begin
        p[i] = d[k];
        k++;
      end
    for (int b = 0; b < 4; b++)
      for (int i = 1; i <= 12; i++)
        if ((i & (i - 1)) != 0 && ((i >> b) & 1) == 1)
          p[1 << b] = p[1 << b] ^ p[i];
    return p;
  endfunction

  task automatic m_dec(
    input  logic [11:0] c,
    output logic [7:0]  d,
    output logic [3:0]  s
  );
    logic [11:0] f;
    int k;
    s = 4'd0;
    for (int i = 1; i <= 12; i++)
      if (c[i-1]) s = s ^ 4'(i);
    f = c;
    if (s >= 4'd1 && s <= 4'd12) f[s-1] = ~f[s-1];
    k = 0;
    d = 8'h00;
    for (int i = 1; i <= 12; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = f[i-1];
        k++;
      end
  endtask

  always @(negedge clk) begin
    item_t       h;
    logic [7:0]  dd;
    logic [3:0]  ss;
    logic        dlv;
    logic        acc;
    if (rst) begin
      exp_q.delete();
      m_count = '0;
    end else if (live) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("word_count", word_count, m_count);
      dlv = (exp_q.size() != 0) && out_ready;
      acc = in_valid && (exp_q.size() < 2);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("out_code", out_code, m_enc(h.d) ^ h.m);
        if (dlv) begin
          m_dec(out_code, dd, ss);
          chk("dec_data", dd, h.d);
          chk("syn_zero", ss == 4'd0, h.m == 12'h000);
          void'(exp_q.pop_front());
          m_count = m_count + 16'd1;
        end
      end
      if (acc) exp_q.push_back('{d: in_data, m: inj_mask});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(
    input logic [7:0]  d,
    input logic [11:0] lit
  );
    chk("model_pin", m_enc(d), lit);
    tick();
    in_valid  = 1'b1;
    in_data   = d;
    inj_mask  = 12'h000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("dir_in_ready", in_ready, 1);
    chk("dir_pre_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("dir_valid", out_valid, 1);
    chk("dir_code", out_code, lit);
    tick();
  endtask

  task automatic run_stream(
    input int pv,
    input int pr,
    input int budget
  );
    int cyc;
    cyc = 0;
    while (stim.size() != 0 && cyc < budget) begin
      tick();
      in_valid = ($urandom_range(99) < pv);
      if (in_valid) begin
        in_data  = stim[0].d;
        inj_mask = stim[0].m;
      end else begin
        in_data  = 8'($urandom);
        inj_mask = 12'($urandom);
      end
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (in_valid && in_ready) void'(stim.pop_front());
      cyc++;
    end
    chk("stream_budget", stim.size(), 0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    rst         = 1'b1;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    inj_mask    = 12'h000;
    out_ready   = 1'b0;
    w_in_data   = 8'h00;
    w_in_valid  = 1'b0;
    w_inj_mask  = 12'h000;
    w_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    live = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_code", out_code, 12'h000);
    chk("rst_word_count", word_count, 0);

    directed(8'h00, 12'h000);
    directed(8'h01, 12'h007);
    directed(8'h80, 12'h888);
    directed(8'hFF, 12'hF77);
    directed(8'h35, 12'h32E);

    // backpressure: two words fill the queue, third must wait
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inj_mask  = 12'h000;
    in_data   = 8'h01;
    tick();
    in_data = 8'h80;
    tick();
    in_data = 8'h35;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_code, 12'h007);
    tick();
    @(negedge clk);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_code", out_code, 12'h007);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", out_code, 12'h007);
    chk("bp_first_ready", in_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_second", out_code, 12'h888);
    chk("bp_second_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third", out_code, 12'h32E);
    repeat (3) tick();

    // exhaustive round trip, clean then every single-bit error
    for (int i = 0; i < 256; i++)
      stim.push_back('{d: 8'(i), m: 12'h000});
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 12; b++)
        stim.push_back('{d: 8'(i), m: 12'(1 << b)});
    run_stream(100, 100, 4000);

    // random handshakes over 1000 words
    pulse_reset();
    for (int i = 0; i < 1000; i++)
      stim.push_back('{
        d: 8'($urandom),
        m: ($urandom_range(1) == 1)
           ? 12'(1 << $urandom_range(11)) : 12'h000
      });
    run_stream(50, 50, 20000);
    chk("stream_count", word_count, 16'd1000);

    // sustained rate with both sides high
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      inj_mask  = 12'h000;
      out_ready = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
    end
    chk("throughput", acc, 20);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // reset with a full queue and a pending handshake
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    rst     = 1'b1;
    in_data = 8'h33;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_word_count", word_count, 0);
    chk("mrst_out_code", out_code, 12'h000);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("mrst_no_stale", word_count, 0);

    // narrow counter wrap, injection disabled
    w_out_ready = 1'b1;
    w_in_valid  = 1'b1;
    w_in_data   = 8'hFF;
    w_inj_mask  = 12'hFFF;
    tick();
    @(negedge clk);
    chk("wrap_valid", w_out_valid, 1);
    chk("wrap_noinj", w_out_code, 12'hF77);
    for (int i = 1; i < 17; i++) begin
      w_in_data = 8'($urandom);
      tick();
    end
    w_in_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_count", w_word_count, 4'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
